periph_apb_bridge: RTL

- Bridges the core/peripheral-side request/grant bus (req/gnt/r_valid protocol) onto the SoC APB peripheral bus.
- Sits directly upstream of the APB bus and its peripheral decoder.
- Performs window decode against the APB peripheral region and runs the APB SETUP/ACCESS sequence.
- Returns read data or an error, and terminates hung slaves with a timeout.

---
 rtl/periph_apb_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/periph_apb_bridge.sv
// periph_apb_bridge: converts the upstream req/gnt/r_valid bus into APB
// SETUP/ACCESS transfers for addresses inside the APB window. Addresses
// outside the window get an error response, and APB slaves that stall
// for too long are aborted with an error.
//
// Upstream handshake: a request is accepted in any cycle where req_i and
// gnt_o are both high. gnt_o is only offered in IDLE, so at most one
// transaction is in flight. Exactly one r_valid_o pulse follows each
// accepted request, and r_rdata_o/r_err_o are meaningful only during
// that pulse.
module periph_apb_bridge #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] APB_BASE       = 32'h1A10_0000,
    parameter logic [ADDR_WIDTH-1:0] APB_END        = 32'h1A11_7FFF,
    parameter int unsigned           TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // The counter only needs to reach TIMEOUT_CYCLES-1; keep at least one
    // bit so a disabled timeout still yields a legal declaration.
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic                  r_err_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic                  psel_q;
    logic                  penable_q;

    logic addr_hit_d;
    logic to_fire_d;

    // Grant is combinational in IDLE; gating with rst_n keeps every output
    // low while reset is held.
    assign gnt_o = req_i & rst_n & (state_q == S_IDLE);

    // Window decode and timeout detection for the current cycle.
    always_comb begin
        addr_hit_d = (addr_i >= APB_BASE) && (addr_i <= APB_END);
        to_fire_d  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    end

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            r_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_o) begin
                        paddr_q   <= addr_i;
                        pwdata_q  <= wdata_i;
                        pwrite_q  <= we_i;
                        r_rdata_q <= '0;
                        if (addr_hit_d) begin
                            r_err_q <= 1'b0;
                            psel_q  <= 1'b1;
                            state_q <= S_SETUP;
                        end else begin
                            // Decode miss never touches the APB bus.
                            r_err_q   <= 1'b1;
                            r_valid_q <= 1'b1;
                            state_q   <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        // A completing slave wins over a timeout in the same cycle.
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        r_err_q   <= pslverr_i;
                        r_rdata_q <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                        r_valid_q <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (to_fire_d) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        r_err_q   <= 1'b1;
                        r_rdata_q <= '0;
                        r_valid_q <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_rdata_o = r_rdata_q;
    assign r_err_o   = r_err_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;

endmodule
